alu_pair_sequencer: RTL

Issue stage directly upstream of `Alu`. It accepts decoded ALU operations over a valid/ready handshake and drives `Alu` operands. It owns the architectural N/V/Z/C flags register. It sequences 64-bit register-pair operations as two 32-bit `Alu` passes: low half, then high half with carry/borrow chained. Results and final flags go downstream to writeback over a second valid/ready handshake.

---
 rtl/alu_pair_sequencer_if.sv | 45 ++++
 rtl/alu_pair_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_pair_sequencer_if.sv
// Handshake and Alu-side bundle for alu_pair_sequencer.
// slave: the sequencer; master: upstream issue, Alu and writeback side.
interface alu_pair_sequencer_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_oper;
    logic                  in_pair;
    logic                  in_flags_wr;
    logic [WORD_WIDTH-1:0] in_a_lo;
    logic [WORD_WIDTH-1:0] in_a_hi;
    logic [WORD_WIDTH-1:0] in_b_lo;
    logic [WORD_WIDTH-1:0] in_b_hi;

    logic [3:0]            alu_oper;
    logic [WORD_WIDTH-1:0] alu_a;
    logic [WORD_WIDTH-1:0] alu_b;
    logic [3:0]            alu_flags;
    logic [WORD_WIDTH-1:0] alu_res;
    logic [3:0]            alu_res_flags;

    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] out_lo;
    logic [WORD_WIDTH-1:0] out_hi;
    logic [3:0]            out_flags;
    logic [3:0]            flags;

    modport slave (
        input  in_valid, in_oper, in_pair, in_flags_wr,
        input  in_a_lo, in_a_hi, in_b_lo, in_b_hi,
        input  alu_res, alu_res_flags, out_ready,
        output in_ready, alu_oper, alu_a, alu_b, alu_flags,
        output out_valid, out_lo, out_hi, out_flags, flags
    );

    modport master (
        output in_valid, in_oper, in_pair, in_flags_wr,
        output in_a_lo, in_a_hi, in_b_lo, in_b_hi,
        output alu_res, alu_res_flags, out_ready,
        input  in_ready, alu_oper, alu_a, alu_b, alu_flags,
        input  out_valid, out_lo, out_hi, out_flags, flags
    );
endinterface

// File: rtl/alu_pair_sequencer.sv
// Issue stage ahead of Alu: owns N/V/Z/C flags, splits 64-bit pair ops into lo/hi passes.
// Ports: clk, rst_n (async low), bus (slave: request in, Alu drive/return, result out).
module alu_pair_sequencer #(
    parameter int WORD_WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_pair_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_XOR = 4'd8;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [3:0]            r_oper;
    logic                  r_pair;
    logic                  r_flags_wr;
    logic [WORD_WIDTH-1:0] r_a_hi;
    logic [WORD_WIDTH-1:0] r_b_hi;
    logic                  r_tmp_z;
    logic [3:0]            r_flags;
    logic [WORD_WIDTH-1:0] r_out_lo;
    logic [WORD_WIDTH-1:0] r_out_hi;
    logic [3:0]            r_out_flags;
    logic [3:0]            r_alu_oper;
    logic [WORD_WIDTH-1:0] r_alu_a;
    logic [WORD_WIDTH-1:0] r_alu_b;
    logic [3:0]            r_alu_flags;

    logic                  w_pair_ok;
    logic [3:0]            w_hi_oper;
    logic [3:0]            w_done_flags;

    always_comb begin
        w_pair_ok = 1'b0;
        unique case (bus.in_oper)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: w_pair_ok = 1'b1;
            default:                               w_pair_ok = 1'b0;
        endcase
    end

    // High pass chains the low pass carry/borrow.
    always_comb begin
        w_hi_oper = r_oper;
        unique case (r_oper)
            OP_ADD:  w_hi_oper = OP_ADC;
            OP_SUB:  w_hi_oper = OP_SBC;
            default: w_hi_oper = r_oper;
        endcase
    end

    // Pair result is zero only if both halves were zero.
    assign w_done_flags = (r_state == S_HI) ?
        {bus.alu_res_flags[3:2], bus.alu_res_flags[1] & r_tmp_z, bus.alu_res_flags[0]} :
        bus.alu_res_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_oper      <= '0;
            r_pair      <= 1'b0;
            r_flags_wr  <= 1'b0;
            r_a_hi      <= '0;
            r_b_hi      <= '0;
            r_tmp_z     <= 1'b0;
            r_flags     <= '0;
            r_out_lo    <= '0;
            r_out_hi    <= '0;
            r_out_flags <= '0;
            r_alu_oper  <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_flags <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_oper      <= bus.in_oper;
                        r_pair      <= bus.in_pair & w_pair_ok;
                        r_flags_wr  <= bus.in_flags_wr;
                        r_a_hi      <= bus.in_a_hi;
                        r_b_hi      <= bus.in_b_hi;
                        r_alu_oper  <= bus.in_oper;
                        r_alu_a     <= bus.in_a_lo;
                        r_alu_b     <= bus.in_b_lo;
                        r_alu_flags <= r_flags;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_LO;
                    end
                end
                S_LO, S_HI: begin
                    if (r_state == S_LO) begin
                        r_out_lo <= bus.alu_res;
                        r_tmp_z  <= bus.alu_res_flags[1];
                    end else begin
                        r_out_hi <= bus.alu_res;
                    end
                    if (r_state == S_LO && r_pair) begin
                        r_alu_oper  <= w_hi_oper;
                        r_alu_a     <= r_a_hi;
                        r_alu_b     <= r_b_hi;
                        r_alu_flags <= bus.alu_res_flags;
                        r_state     <= S_HI;
                    end else begin
                        if (r_state == S_LO) begin
                            r_out_hi <= '0;
                        end
                        r_out_flags <= w_done_flags;
                        r_out_valid <= 1'b1;
                        r_alu_oper  <= '0;
                        r_alu_a     <= '0;
                        r_alu_b     <= '0;
                        if (r_flags_wr) begin
                            r_flags     <= w_done_flags;
                            r_alu_flags <= w_done_flags;
                        end else begin
                            r_alu_flags <= r_flags;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_lo    = r_out_lo;
    assign bus.out_hi    = r_out_hi;
    assign bus.out_flags = r_out_flags;
    assign bus.flags     = r_flags;
    assign bus.alu_oper  = r_alu_oper;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_flags = r_alu_flags;
endmodule
